alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Decode/issue stage that generates the ALU command interface: ALU_Control, branch_op, operand_A, operand_B.
- Accepts one instruction per beat on a valid/ready input, together with pc and the rs1/rs2 register data.
- Presents the registered decode on a valid/ready output to the ALU/execute side.
- A 2-entry skid buffer sustains 1 instruction/cycle under back-pressure with no combinational ready path.

Parameters:
DATA_W, 32, width of pc, rs1/rs2 data, operands and imm; only 32 supported (RV32I).

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_instr  input  32  RV32I instruction word
in_pc  input  DATA_W  instruction address
in_rs1  input  DATA_W  rs1 register value
in_rs2  input  DATA_W  rs2 register value
out_valid  output  1  issued beat valid
out_ready  input  1  downstream accepts
ALU_Control  output  6  ALU operation code
branch_op  output  1  conditional branch
operand_A  output  DATA_W  ALU operand A
operand_B  output  DATA_W  ALU operand B
imm  output  DATA_W  sign-extended immediate (branch/jump offset, store offset)
illegal  output  1  instruction not decodable

Behaviour:
- Reset: all outputs 0. in_ready=1. Both buffer entries invalid.
- Transfer occurs on in_valid&in_ready, and on out_valid&out_ready.
- Latency: accepted beat appears on out_* the next cycle when the buffer is empty.
- Storage: main entry (drives outputs) plus skid entry.
  - in_ready = !skid_valid, registered.
  - Accept while main is full and not draining -> beat goes to skid.
  - Main drains -> skid moves to main the same edge.
  - Order is strictly preserved.
- Full buffer (main+skid) -> in_ready=0 until one output transfer completes.
- Simultaneous accept and drain with skid empty -> new beat loads main directly. out_valid stays 1; no bubble.
- flush: clears both valid bits at the edge, overriding any same-cycle accept (that beat is dropped).
  - Next cycle: out_valid=0, in_ready=1.
- Payload registers hold their value when the entry is empty. They are never cleared except by reset.
- Reset asserted mid-operation clears everything immediately (asynchronous). No beat survives.
- ALU_Control encoding:
  - ADD 000000, SUB 001000, SLT/BLT 000010, SLTU 000011, BLTU 010110, BGE 010101, BGEU 010111.
  - OR 000110, XOR 000100, AND 000111.
  - SLL 000001, SRL 000101, SRA 001101.
  - BEQ 010000, BNE 010001, JAL 011111, JALR 111111.
- Opcode mapping (operand_A / operand_B / ALU_Control):
  - LUI 0110111: 0 / U-imm / ADD.
  - AUIPC 0010111: pc / U-imm / ADD.
  - JAL 1101111: pc+4 / 0 / JAL; imm=J-imm.
  - JALR 1100111: pc+4 / 0 / JALR; imm=I-imm.
  - BRANCH 1100011: rs1 / rs2 / by funct3; branch_op=1; imm=B-imm.
  - LOAD 0000011: rs1 / I-imm / ADD.
  - STORE 0100011: rs1 / S-imm / ADD; imm=S-imm.
  - OP-IMM 0010011: rs1 / I-imm / by funct3. Shift-immediates use operand_B = zero-extended imm[4:0]; SRAI when instr[30]=1.
  - OP 0110011: rs1 / rs2 / by funct3+instr[30]. Shifts use operand_B = zero-extended rs2[4:0].
- branch_op=0 for all non-BRANCH opcodes.
- imm = 0 where not listed above.
- pc+4 wraps modulo 2^32.

Optional Feature:
- Macro: ALU_OP_ISSUE_ILLEGAL_CHECK_EN.
- Defined: illegal=1 for any of:
  - unlisted opcode;
  - BRANCH funct3 010/011;
  - LOAD funct3 011/110/111;
  - STORE funct3 >010;
  - JALR funct3!=000;
  - OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
  - SLLI funct7!=0;
  - SRLI/SRAI funct7 not 0000000/0100000.
- Defined, on illegal: ALU_Control=000000, operands=0, branch_op=0. The beat still flows through the handshake.
- Not defined: illegal tied 0. Unlisted opcodes decode as ADD with operands 0. No funct checks.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> out_valid=0, in_ready=1, ALU_Control=0 immediately. After release, first beat out one cycle after accept.
- ADD x,rs1=5,rs2=7 (0x00208033) then SUB (0x40208033), out_ready=1 -> consecutive cycles: ALU_Control 000000 then 001000, operands 5/7 both times.
- BGEU (funct3 111), rs1=3, rs2=0xFFFFFFFF, offset -8 -> ALU_Control 010111, branch_op=1, imm=0xFFFFFFF8.
- JAL at pc=0xFFFFFFFC -> ALU_Control 011111, operand_A=0x00000000 (wrap). SRAI shamt 4 -> operand_B=4, ALU_Control 001101.
- Back-pressure: stream 4 beats with out_ready=0 -> accepts exactly 2, in_ready=0. Release -> all 4 emerge in order with no bubble.
- Simultaneous flush with in_valid and full buffer -> next cycle out_valid=0, in_ready=1, the incoming beat never issues. With macro defined, opcode 0x0000007F -> illegal=1, ALU_Control=000000.

Source files
------------

// File: rtl/alu_op_issue.sv
// RV32I decode/issue stage: decodes one instruction per beat into the ALU command
// and presents it through a 2-entry skid buffer. Define ALU_OP_ISSUE_ILLEGAL_CHECK_EN to flag undecodable instructions.
module alu_op_issue #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        ALU_Control,
    output logic              branch_op,
    output logic [DATA_W-1:0] operand_A,
    output logic [DATA_W-1:0] operand_B,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_BLTU = 6'b010110;
    localparam logic [5:0] ALU_BGE  = 6'b010101;
    localparam logic [5:0] ALU_BGEU = 6'b010111;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_BEQ  = 6'b010000;
    localparam logic [5:0] ALU_BNE  = 6'b010001;
    localparam logic [5:0] ALU_JAL  = 6'b011111;
    localparam logic [5:0] ALU_JALR = 6'b111111;

    typedef struct packed {
        logic [5:0]        ctrl;
        logic              br;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] imm_v;
        logic              ill;
    } beat_t;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [DATA_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [DATA_W-1:0] w_shamt_i, w_shamt_r, w_pc4;
    logic              w_acc, w_main_free;
    beat_t             w_raw, w_dec;
    beat_t             r_main, r_skid;
    logic              r_main_valid, r_skid_valid;

    assign w_opcode  = in_instr[6:0];
    assign w_funct3  = in_instr[14:12];
    assign w_imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u   = {in_instr[31:12], 12'b0};
    assign w_imm_j   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_shamt_i = {{(DATA_W-5){1'b0}}, in_instr[24:20]};
    assign w_shamt_r = {{(DATA_W-5){1'b0}}, in_rs2[4:0]};
    assign w_pc4     = in_pc + DATA_W'(4);

    always_comb begin
        w_raw = '0;
        case (w_opcode)
            OPC_LUI:   w_raw.op_b = w_imm_u;
            OPC_AUIPC: begin w_raw.op_a = in_pc; w_raw.op_b = w_imm_u; end
            OPC_JAL:   begin w_raw.op_a = w_pc4; w_raw.ctrl = ALU_JAL;  w_raw.imm_v = w_imm_j; end
            OPC_JALR:  begin w_raw.op_a = w_pc4; w_raw.ctrl = ALU_JALR; w_raw.imm_v = w_imm_i; end
            OPC_BRANCH: begin
                w_raw.op_a  = in_rs1;
                w_raw.op_b  = in_rs2;
                w_raw.br    = 1'b1;
                w_raw.imm_v = w_imm_b;
                case (w_funct3)
                    3'b000:  w_raw.ctrl = ALU_BEQ;
                    3'b001:  w_raw.ctrl = ALU_BNE;
                    3'b100:  w_raw.ctrl = ALU_SLT;
                    3'b101:  w_raw.ctrl = ALU_BGE;
                    3'b110:  w_raw.ctrl = ALU_BLTU;
                    3'b111:  w_raw.ctrl = ALU_BGEU;
                    default: w_raw.ctrl = ALU_ADD;
                endcase
            end
            OPC_LOAD:  begin w_raw.op_a = in_rs1; w_raw.op_b = w_imm_i; end
            OPC_STORE: begin w_raw.op_a = in_rs1; w_raw.op_b = w_imm_s; w_raw.imm_v = w_imm_s; end
            OPC_OPIMM, OPC_OP: begin
                // Register and immediate forms share funct3 decoding; only operand B and SUB differ.
                w_raw.op_a = in_rs1;
                w_raw.op_b = (w_opcode == OPC_OP) ? in_rs2 : w_imm_i;
                case (w_funct3)
                    3'b000:  w_raw.ctrl = (w_opcode == OPC_OP && in_instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_raw.ctrl = ALU_SLL;
                    3'b010:  w_raw.ctrl = ALU_SLT;
                    3'b011:  w_raw.ctrl = ALU_SLTU;
                    3'b100:  w_raw.ctrl = ALU_XOR;
                    3'b101:  w_raw.ctrl = in_instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_raw.ctrl = ALU_OR;
                    default: w_raw.ctrl = ALU_AND;
                endcase
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    w_raw.op_b = (w_opcode == OPC_OP) ? w_shamt_r : w_shamt_i;
            end
            default: ;
        endcase
    end

`ifdef ALU_OP_ISSUE_ILLEGAL_CHECK_EN
    logic [6:0] w_funct7;
    logic       w_illegal;
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
            OPC_JALR:   w_illegal = (w_funct3 != 3'b000);
            OPC_BRANCH: w_illegal = (w_funct3[2:1] == 2'b01);
            OPC_LOAD:   w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
            OPC_STORE:  w_illegal = (w_funct3 > 3'b010);
            OPC_OP:     w_illegal = (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) ||
                                    (w_funct7 == 7'b0100000 && w_funct3 != 3'b000 && w_funct3 != 3'b101);
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001)
                    w_illegal = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_illegal = (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_dec = w_raw;
        if (w_illegal) begin
            w_dec     = '0;
            w_dec.ill = 1'b1;
        end
    end
`else
    assign w_dec = w_raw;
`endif

    assign w_acc       = in_valid && !r_skid_valid;
    assign w_main_free = !r_main_valid || out_ready;

    // Main entry drives the outputs; the skid entry only fills while main is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_main_valid;
    assign ALU_Control = r_main.ctrl;
    assign branch_op   = r_main.br;
    assign operand_A   = r_main.op_a;
    assign operand_B   = r_main.op_b;
    assign imm         = r_main.imm_v;
    assign illegal     = r_main.ill;
endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed vector table, hand-written handshake
// sequences and randomized traffic checked against an occupancy/decode reference model.
module tb_alu_op_issue;
    typedef struct packed {
        logic [5:0]  ctrl;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic        ill;
    } pay_t;

    typedef struct {
        string       nm;
        logic [31:0] ins, pc, ra, rb;
        pay_t        exp;
    } vec_t;

`ifdef ALU_OP_ISSUE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    // funct3-indexed ALU and branch codes
    localparam logic [5:0] ALU_TAB [8] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                                          6'b000100, 6'b000101, 6'b000110, 6'b000111};
    localparam logic [5:0] BR_TAB  [8] = '{6'b010000, 6'b010001, 6'b000000, 6'b000000,
                                          6'b000010, 6'b010101, 6'b010110, 6'b010111};

    logic        clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic [5:0]  ALU_Control;
    logic        branch_op, illegal;
    logic [31:0] operand_A, operand_B, imm;
    pay_t        act_pay;

    int checks = 0;
    int failures = 0;
    pay_t mq[$];
    vec_t vecs[$];

    alu_op_issue #(.DATA_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Control(ALU_Control), .branch_op(branch_op),
        .operand_A(operand_A), .operand_B(operand_B), .imm(imm), .illegal(illegal)
    );

    assign act_pay = {ALU_Control, branch_op, operand_A, operand_B, imm, illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic pay_t ref_decode(input logic [31:0] ins, pc, ra, rb);
        pay_t        p;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        bit          bad;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        iimm = 32'($signed(ins[31:20]));
        simm = 32'($signed({ins[31:25], ins[11:7]}));
        bimm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        jimm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        uimm = ins & 32'hFFFFF000;
        p    = '0;
        bad  = 1'b0;
        case (op)
            7'h37: p.b = uimm;
            7'h17: begin p.a = pc; p.b = uimm; end
            7'h6F: begin p.a = pc + 32'd4; p.ctrl = 6'b011111; p.im = jimm; end
            7'h67: begin p.a = pc + 32'd4; p.ctrl = 6'b111111; p.im = iimm; bad = (f3 != 3'd0); end
            7'h63: begin
                p.a = ra; p.b = rb; p.br = 1'b1; p.im = bimm; p.ctrl = BR_TAB[f3];
                bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h03: begin p.a = ra; p.b = iimm; bad = (f3 == 3'd3 || f3 >= 3'd6); end
            7'h23: begin p.a = ra; p.b = simm; p.im = simm; bad = (f3 > 3'd2); end
            7'h13: begin
                p.a = ra; p.ctrl = ALU_TAB[f3]; p.b = iimm;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    p.b = {27'd0, ins[24:20]};
                    if (f3 == 3'd5 && ins[30]) p.ctrl = 6'b001101;
                    bad = (f3 == 3'd1) ? (f7 != 7'd0) : (f7 != 7'd0 && f7 != 7'h20);
                end
            end
            7'h33: begin
                p.a = ra; p.ctrl = ALU_TAB[f3];
                p.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, rb[4:0]} : rb;
                if (ins[30] && f3 == 3'd0) p.ctrl = 6'b001000;
                if (ins[30] && f3 == 3'd5) p.ctrl = 6'b001101;
                bad = (f7 != 7'd0 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
            end
            default: bad = 1'b1;
        endcase
        if (ILL_EN && bad) begin
            p     = '0;
            p.ill = 1'b1;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Compare handshake against buffer occupancy, score the transfers, advance one clock.
    task automatic tick();
        bit exp_ir, exp_ov;
        exp_ir = (mq.size() < 2);
        exp_ov = (mq.size() != 0);
        chk("in_ready", 128'(in_ready), 128'(exp_ir));
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        if (exp_ov && out_ready) begin
            chk("payload", 128'(act_pay), 128'(mq[0]));
            void'(mq.pop_front());
        end
        if (in_valid && exp_ir) mq.push_back(ref_decode(in_instr, in_pc, in_rs1, in_rs2));
        if (flush) mq.delete();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [31:0] ins, pc, ra, rb);
        in_instr = ins; in_pc = pc; in_rs1 = ra; in_rs2 = rb;
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ins, pc, ra, rb,
                           input logic [5:0] c, input logic br,
                           input logic [31:0] ea, eb, ei, input logic ill);
        vec_t v;
        v.nm = nm; v.ins = ins; v.pc = pc; v.ra = ra; v.rb = rb;
        v.exp.ctrl = c; v.exp.br = br; v.exp.a = ea; v.exp.b = eb; v.exp.im = ei; v.exp.ill = ill;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        r  = $urandom;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return {r[31:7], 7'h37};
            1: return {r[31:7], 7'h17};
            2: return {r[31:7], 7'h6F};
            3: return {r[31:15], 3'd0, r[11:7], 7'h67};
            4: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd7;
                return {r[31:15], f3, r[11:7], 7'h63};
            end
            5: begin
                if (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'd2;
                return {r[31:15], f3, r[11:7], 7'h03};
            end
            6: return {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
            7: begin
                f7 = (f3 == 3'd5 && r[0]) ? 7'h20 : 7'h00;
                if (f3 == 3'd1 || f3 == 3'd5) return {f7, r[24:15], f3, r[11:7], 7'h13};
                return {r[31:15], f3, r[11:7], 7'h13};
            end
            8: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
                return {f7, r[24:15], f3, r[11:7], 7'h33};
            end
            default: begin
                case (r[1:0])
                    2'd0:    return {r[31:7], 7'h7F};
                    2'd1:    return {r[31:7], 7'h0F};
                    2'd2:    return {r[31:7], 7'h73};
                    default: return {r[31:7], 7'h00};
                endcase
            end
        endcase
    endfunction

    initial begin
        int          idx;
        bit          acc;
        logic [31:0] bp_ins [4];
        logic [5:0]  bp_exp [4];

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clock);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_payload", 128'(act_pay), 128'(0));
        reset_n = 1'b1;
        @(negedge clock);

        // ADD then SUB back to back
        out_ready = 1'b1; in_valid = 1'b1;
        drive(32'h00208033, 32'h0, 32'd5, 32'd7);
        tick();
        chk("add_ctrl", 128'(ALU_Control), 128'(6'b000000));
        chk("add_ops", {operand_A, operand_B}, {32'd5, 32'd7});
        drive(32'h40208033, 32'h0, 32'd5, 32'd7);
        tick();
        chk("sub_valid", 128'(out_valid), 128'(1));
        chk("sub_ctrl", 128'(ALU_Control), 128'(6'b001000));
        chk("sub_ops", {operand_A, operand_B}, {32'd5, 32'd7});
        in_valid = 1'b0;
        tick();

        add_vec("bgeu",  32'hFE20FCE3, 32'h0,        32'd3,        32'hFFFFFFFF, 6'b010111, 1'b1, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0);
        add_vec("jal",   32'h008000EF, 32'hFFFFFFFC, 32'h11,       32'h22,       6'b011111, 1'b0, 32'h0,        32'h0,        32'h8,        1'b0);
        add_vec("srai",  32'h4040D093, 32'h0,        32'h80000000, 32'h7,        6'b001101, 1'b0, 32'h80000000, 32'h4,        32'h0,        1'b0);
        add_vec("lui",   32'h123450B7, 32'h40,       32'h9,        32'h9,        6'b000000, 1'b0, 32'h0,        32'h12345000, 32'h0,        1'b0);
        add_vec("auipc", 32'h00001097, 32'h100,      32'h9,        32'h9,        6'b000000, 1'b0, 32'h100,      32'h1000,     32'h0,        1'b0);
        add_vec("jalr",  32'h00C100E7, 32'h200,      32'h9,        32'h9,        6'b111111, 1'b0, 32'h204,      32'h0,        32'hC,        1'b0);
        add_vec("lw",    32'hFFC12083, 32'h0,        32'h1000,     32'h9,        6'b000000, 1'b0, 32'h1000,     32'hFFFFFFFC, 32'h0,        1'b0);
        add_vec("sw",    32'h0020A423, 32'h0,        32'h40,       32'd99,       6'b000000, 1'b0, 32'h40,       32'h8,        32'h8,        1'b0);
        add_vec("sll",   32'h002090B3, 32'h0,        32'h1,        32'hFFFFFF23, 6'b000001, 1'b0, 32'h1,        32'h3,        32'h0,        1'b0);
        add_vec("andi",  32'hFFF0F093, 32'h0,        32'h55,       32'h9,        6'b000111, 1'b0, 32'h55,       32'hFFFFFFFF, 32'h0,        1'b0);
        add_vec("beq",   32'h00208863, 32'h0,        32'hA,        32'hB,        6'b010000, 1'b1, 32'hA,        32'hB,        32'h10,       1'b0);
        add_vec("sltiu", 32'h0050B093, 32'h0,        32'h77,       32'h9,        6'b000011, 1'b0, 32'h77,       32'h5,        32'h0,        1'b0);
        add_vec("unlisted", 32'h0000007F, 32'h10,    32'h1234,     32'h5678,     6'b000000, 1'b0, 32'h0,        32'h0,        32'h0,        ILL_EN);

        foreach (vecs[k]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            drive(vecs[k].ins, vecs[k].pc, vecs[k].ra, vecs[k].rb);
            tick();
            in_valid = 1'b0;
            chk({vecs[k].nm, "_valid"}, 128'(out_valid), 128'(1));
            chk(vecs[k].nm, 128'(act_pay), 128'(vecs[k].exp));
            tick();
        end

        // Back-pressure: four distinct ops against a stalled consumer
        bp_ins = '{32'h00208033, 32'h40208033, 32'h0020C033, 32'h0020E033};
        bp_exp = '{6'b000000, 6'b001000, 6'b000100, 6'b000110};
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) drive(bp_ins[idx], 32'h0, 32'(idx + 1), 32'h3);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", 128'(idx), 128'(2));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_no_bubble", 128'(out_valid), 128'(1));
            chk("bp_order", 128'(ALU_Control), 128'(bp_exp[j]));
            in_valid = (idx < 4);
            if (idx < 4) drive(bp_ins[idx], 32'h0, 32'(idx + 1), 32'h3);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_all_accepted", 128'(idx), 128'(4));
        in_valid = 1'b0;
        tick();

        // Flush with a full buffer and a pending beat
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h40208033, 32'h0, 32'h1, 32'h2); tick();
        drive(32'h0020C033, 32'h0, 32'h3, 32'h4); tick();
        flush = 1'b1;
        drive(32'h0020E033, 32'h0, 32'h5, 32'h6); tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_out_valid", 128'(out_valid), 128'(0));
        chk("flush_full_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush that overrides a same-cycle accept
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h40208033, 32'h0, 32'h1, 32'h2); tick();
        flush = 1'b1;
        drive(32'h0020C033, 32'h0, 32'h3, 32'h4); tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_acc_out_valid", 128'(out_valid), 128'(0));
        repeat (3) tick();

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h40208033, 32'h0, 32'h1, 32'h2); tick();
        drive(32'h4040D093, 32'h0, 32'h3, 32'h4); tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        mq.delete();
        chk("async_rst_out_valid", 128'(out_valid), 128'(0));
        chk("async_rst_in_ready", 128'(in_ready), 128'(1));
        chk("async_rst_ctrl", 128'(ALU_Control), 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        drive(32'h40208033, 32'h0, 32'h8, 32'h9);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 128'(out_valid), 128'(1));
        chk("post_rst_ctrl", 128'(ALU_Control), 128'(6'b001000));
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            drive(gen_instr(), ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom, $urandom, $urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
